apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Upstream APB requester that feeds the team's APB SRAM slave.
- Accepts simple read/write commands through a valid/ready port and buffers them in a small command FIFO.
- Sequences each command through the APB SETUP and ACCESS phases, then returns one response per command: read data, error and timeout status.
- A watchdog ends any ACCESS phase that never sees PREADY, so an out-of-range read cannot hang the bus.

Parameters:
ADDR_BUS_WIDTH, 32, width of cmd_addr and PWADDR
DATA_BUS_WIDTH, 32, width of write/read data paths
CMD_DEPTH, 4, command FIFO entries (power of two, at least 2)
TIMEOUT, 16, maximum ACCESS cycles without PREADY before the transfer is aborted

Ports:
PCLK  in  1  clock; all logic on rising edge
PRESET  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !fifo_full
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_BUS_WIDTH  transfer address
cmd_wdata  in  DATA_BUS_WIDTH  write data (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_BUS_WIDTH  read data; 0 for writes and timeouts
rsp_err  out  1  PSLVERR sampled with PREADY, or timeout
rsp_timeout  out  1  transfer aborted by watchdog
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWADDR  out  ADDR_BUS_WIDTH  APB address
PWDATA  out  DATA_BUS_WIDTH  APB write data
PRDATA  in  DATA_BUS_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset (async, immediate):
  - All outputs 0.
  - FIFO emptied, FSM to IDLE, watchdog cleared.
  - Any in-flight transfer is discarded with no response.
  - Exception: cmd_ready returns to 1 on the first edge after PRESET deasserts.
- FIFO:
  - Push when cmd_valid and cmd_ready.
  - Pop when the FSM leaves IDLE or RESP toward SETUP.
  - Simultaneous push and pop are legal when not full.
  - When full, cmd_ready is 0 regardless of a same-cycle pop.
  - Pointers wrap modulo CMD_DEPTH; occupancy counter is sized for CMD_DEPTH.
- FSM states: IDLE, SETUP, ACCESS, RESP. Every state transition is made on a rising edge of PCLK.
  - IDLE: PSEL=0, PENABLE=0. If FIFO non-empty, pop head into PWRITE/PWADDR/PWDATA registers and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, address/data/direction stable. Unconditionally go to ACCESS; clear the watchdog.
  - ACCESS: PSEL=1, PENABLE=1, watchdog increments each cycle.
    - If PREADY=1: capture PRDATA (reads only, else 0) and PSLVERR into the response registers, set rsp_timeout=0, go to RESP.
    - Else if watchdog reaches TIMEOUT-1: rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - RESP: PSEL=0, PENABLE=0, rsp_valid=1. Response registers are held stable until rsp_ready.
    - On rsp_ready with FIFO non-empty: pop and go directly to SETUP.
    - On rsp_ready with FIFO empty: go to IDLE.
- PREADY and PSLVERR are sampled only in ACCESS. A PREADY left high by the slave from a previous transfer and seen during SETUP or IDLE is ignored.
- Exactly one response per accepted command, in command order. No new APB transfer starts while a response is pending.
- PWADDR, PWDATA and PWRITE hold their last values when idle. They change only on entry to SETUP.
- Latency against the SRAM slave (PREADY one cycle into ACCESS), command pushed at edge E0 into an empty, idle block:
  - SETUP at E1, ACCESS at E2, PREADY seen high at E3.
  - rsp_valid=1 after E4.
  - Back-to-back throughput with rsp_ready held high: 4 cycles per transfer.
- Reset asserted mid-ACCESS: PSEL and PENABLE drop immediately (async). No response for the aborted command.

Test Plan:
- Reset, then read addr 5 (slave preloads mem[i]=i) -> PSEL high at E1, PENABLE at E2; rsp_valid after E4 with rsp_rdata=5, rsp_err=0, rsp_timeout=0.
- Write 0xA5 to addr 3, then read addr 3, rsp_ready=1 -> two responses in order; write rsp_rdata=0, read rsp_rdata=0xA5; no IDLE cycle between the transfers (RESP->SETUP).
- Read addr 40 (slave raises PSLVERR but never PREADY) -> after 16 ACCESS cycles: rsp_err=1, rsp_timeout=1, rsp_rdata=0, PSEL=0.
- Write addr 40 -> PREADY with PSLVERR=1: rsp_err=1, rsp_timeout=0.
- rsp_ready=0, push 6 reads -> 5 accepted (1 in RESP, 4 in FIFO), then cmd_ready=0. Release rsp_ready -> 5 responses with data equal to addresses, cmd_ready returns to 1 after the first pop.
- Assert PRESET during ACCESS of a read -> PSEL, PENABLE, rsp_valid drop immediately; FIFO empty; no response after release; a new read of addr 7 returns 7.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command/response port and APB master bus of apb_master_bridge
interface apb_master_bridge_if #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDR_BUS_WIDTH-1:0] cmd_addr;
  logic [DATA_BUS_WIDTH-1:0] cmd_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_BUS_WIDTH-1:0] rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;
  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_BUS_WIDTH-1:0] PWADDR;
  logic [DATA_BUS_WIDTH-1:0] PWDATA;
  logic [DATA_BUS_WIDTH-1:0] PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, PWADDR, PWDATA
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, PWADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: APB requester with command FIFO, single response register and ACCESS watchdog
module apb_master_bridge #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT = 16
) (
  input logic PCLK,
  input logic PRESET,
  apb_master_bridge_if.master bus
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam int EW = 1 + ADDR_BUS_WIDTH + DATA_BUS_WIDTH;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t st;
  logic [EW-1:0] mem [CMD_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wd;
  logic rdy_en, push, pop;
  // cmd_ready stays low through reset and rises on the first edge after release
  assign bus.cmd_ready = rdy_en && cnt != CW'(CMD_DEPTH);
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign pop = cnt != '0 && (st == IDLE || (st == RESP && bus.rsp_ready));
  always_ff @(posedge PCLK)
    if (push) mem[wp] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      st <= IDLE;
      wd <= '0;
      bus.PSEL <= 1'b0;
      bus.PENABLE <= 1'b0;
      bus.PWRITE <= 1'b0;
      bus.PWADDR <= '0;
      bus.PWDATA <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      if (pop) begin
        {bus.PWRITE, bus.PWADDR, bus.PWDATA} <= mem[rp];
        bus.PSEL <= 1'b1;
        st <= SETUP;
      end
      case (st)
        SETUP: begin
          bus.PENABLE <= 1'b1;
          wd <= '0;
          st <= ACCESS;
        end
        ACCESS: begin
          wd <= wd + WW'(1);
          if (bus.PREADY || wd == WW'(TIMEOUT - 1)) begin
            bus.PSEL <= 1'b0;
            bus.PENABLE <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= bus.PREADY && !bus.PWRITE ? bus.PRDATA : '0;
            bus.rsp_err <= bus.PREADY ? bus.PSLVERR : 1'b1;
            bus.rsp_timeout <= !bus.PREADY;
            st <= RESP;
          end
        end
        RESP:
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            if (!pop) st <= IDLE;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed and random checks of apb_master_bridge against an SRAM slave and a queue model
module tb_apb_master_bridge;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  apb_master_bridge_if #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32)) bus ();
  apb_master_bridge #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32), .CMD_DEPTH(4), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus));
  always #5 PCLK = ~PCLK;

  // SRAM slave: 32 words, PREADY registered one cycle into ACCESS plus optional random wait
  logic [31:0] smem [32];
  logic s_rdy = 1'b0;
  logic [31:0] s_rd = '0;
  int wcnt = 0;
  bit rnd = 0;
  assign bus.PREADY = s_rdy;
  assign bus.PRDATA = s_rd;
  assign bus.PSLVERR = bus.PSEL && bus.PENABLE && bus.PWADDR >= 32;
  always @(posedge PCLK) begin
    s_rd <= $urandom;
    if (bus.PSEL && bus.PENABLE && !s_rdy && (bus.PWRITE || bus.PWADDR < 32) && wcnt == 0) begin
      s_rdy <= 1'b1;
      if (!bus.PWRITE) s_rd <= smem[bus.PWADDR[4:0]];
      else if (bus.PWADDR < 32) smem[bus.PWADDR[4:0]] <= bus.PWDATA;
      wcnt <= rnd ? int'($urandom_range(0, 5)) : 0;
    end else begin
      s_rdy <= 1'b0;
      if (bus.PSEL && bus.PENABLE && wcnt > 0) wcnt <= wcnt - 1;
    end
  end

  typedef struct packed {logic [31:0] d; logic e; logic t;} rsp_t;
  rsp_t q[$];
  logic [31:0] rmem [32];
  int tests = 0, fails = 0, n_acc = 0, cyc = 0;
  int rise[$];
  bit prev_psel = 0, rr_rand = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    rsp_t x;
    logic [31:0] a;
    if (rr_rand) bus.rsp_ready = 1'($urandom_range(0, 1));
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (q.size() == 0) chk("rsp_without_cmd", bus.rsp_valid, 0);
      else begin
        x = q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, x.d);
        chk("rsp_err", bus.rsp_err, x.e);
        chk("rsp_timeout", bus.rsp_timeout, x.t);
      end
    end
    if (bus.cmd_valid && bus.cmd_ready) begin
      n_acc++;
      a = bus.cmd_addr;
      if (a >= 32) x = {32'd0, 1'b1, !bus.cmd_write};
      else if (bus.cmd_write) begin
        rmem[a[4:0]] = bus.cmd_wdata;
        x = {32'd0, 1'b0, 1'b0};
      end else x = {rmem[a[4:0]], 1'b0, 1'b0};
      q.push_back(x);
    end
    @(posedge PCLK);
    #1;
    cyc++;
    if (bus.PSEL && !prev_psel) rise.push_back(cyc);
    prev_psel = bus.PSEL;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit ok = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr = a;
    bus.cmd_wdata = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    if (!ok) chk("cmd_accept", ok, 1);
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 500 && q.size() > 0; i++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    int na, base;
    for (int i = 0; i < 32; i++) begin
      smem[i] = i;
      rmem[i] = i;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    chk("reset_psel", bus.PSEL, 0);
    chk("reset_penable", bus.PENABLE, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_cmd_ready", bus.cmd_ready, 0);
    chk("reset_pwaddr", bus.PWADDR, 0);
    PRESET = 1'b0;
    tick();
    chk("cmd_ready_after_reset", bus.cmd_ready, 1);

    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = 5;
    tick();
    bus.cmd_valid = 1'b0;
    chk("psel_e0", bus.PSEL, 0);
    tick();
    chk("psel_e1", bus.PSEL, 1);
    chk("penable_e1", bus.PENABLE, 0);
    chk("pwaddr_e1", bus.PWADDR, 5);
    tick();
    chk("penable_e2", bus.PENABLE, 1);
    tick();
    chk("rsp_valid_e3", bus.rsp_valid, 0);
    tick();
    chk("rsp_valid_e4", bus.rsp_valid, 1);
    chk("psel_resp", bus.PSEL, 0);
    drain();

    rise.delete();
    send(1, 3, 32'hA5);
    send(0, 3, 0);
    drain();
    chk("b2b_rises", rise.size(), 2);
    if (rise.size() >= 2) chk("b2b_gap", rise[1] - rise[0], 4);
    chk("hold_pwaddr", bus.PWADDR, 3);

    bus.rsp_ready = 1'b0;
    send(0, 40, 0);
    na = 0;
    for (int i = 0; i < 100 && !bus.rsp_valid; i++) begin
      na += int'(bus.PENABLE);
      tick();
    end
    chk("timeout_access_cycles", na, 16);
    chk("timeout_psel", bus.PSEL, 0);
    drain();

    send(1, 40, 32'h1234);
    drain();

    bus.rsp_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 5; i++) send(0, 10 + i, 0);
    chk("accepted_five", n_acc - base, 5);
    chk("full_cmd_ready", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 15;
    repeat (8) tick();
    bus.cmd_valid = 1'b0;
    chk("sixth_rejected", n_acc - base, 5);
    bus.rsp_ready = 1'b1;
    tick();
    chk("cmd_ready_after_pop", bus.cmd_ready, 1);
    drain();

    send(0, 20, 0);
    send(0, 21, 0);
    send(0, 22, 0);
    for (int i = 0; i < 20 && !bus.PENABLE; i++) tick();
    chk("pre_reset_access", bus.PENABLE, 1);
    PRESET = 1'b1;
    #1;
    chk("async_psel", bus.PSEL, 0);
    chk("async_penable", bus.PENABLE, 0);
    chk("async_rsp_valid", bus.rsp_valid, 0);
    q.delete();
    tick();
    PRESET = 1'b0;
    na = 0;
    for (int i = 0; i < 30; i++) begin
      na += int'(bus.PSEL);
      tick();
    end
    chk("no_transfer_after_reset", na, 0);
    chk("fifo_empty_ready", bus.cmd_ready, 1);
    send(0, 7, 0);
    drain();

    rnd = 1;
    rr_rand = 1;
    for (int i = 0; i < 40; i++)
      send(1'($urandom_range(0, 1)), $urandom_range(0, 35), $urandom);
    rr_rand = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
